// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: memory op codes,
// exception codes, FSM state encoding, the MEM/WB register layout and the
// load extraction/extension helper.
package mem_stage_pkg;

    localparam int EXP_CODE_W   = 4;
    localparam int HART_STATE_W = 2;
    localparam int MEM_OP_W     = 4;

    localparam logic [EXP_CODE_W-1:0] EXP_NONE        = 4'd0;
    localparam logic [EXP_CODE_W-1:0] EXP_LD_MISALIGN = 4'd4;
    localparam logic [EXP_CODE_W-1:0] EXP_ST_MISALIGN = 4'd6;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NOP = 4'd0,
        MEM_OP_LB  = 4'd1,
        MEM_OP_LH  = 4'd2,
        MEM_OP_LW  = 4'd3,
        MEM_OP_LBU = 4'd4,
        MEM_OP_LHU = 4'd5,
        MEM_OP_SB  = 4'd6,
        MEM_OP_SH  = 4'd7,
        MEM_OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_WAIT  = 2'd1,
        MEM_HOLD  = 2'd2,
        MEM_DRAIN = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic [EXP_CODE_W-1:0]   exp_code;
        logic [31:0]             pc;
        logic                    en;
        logic [4:0]              rd_addr;
        logic                    gpr_we_;
        logic [31:0]             out;
        logic [HART_STATE_W-1:0] hart_st;
    } mem_wb_t;

    // Empty slot in WB: nothing valid, no register write, no exception.
    localparam mem_wb_t MEM_WB_BUBBLE = '{
        exp_code: EXP_NONE,
        pc:       32'd0,
        en:       1'b0,
        rd_addr:  5'd0,
        gpr_we_:  1'b1,
        out:      32'd0,
        hart_st:  '0
    };

    // Pick the addressed byte/halfword out of a read word and extend it.
    function automatic logic [31:0] load_extend(input mem_op_e op,
                                                input logic [1:0] lane,
                                                input logic [31:0] data);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = data >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? data[31:16] : data[15:0];
        case (op)
            MEM_OP_LB:  res = {{24{b[7]}}, b};
            MEM_OP_LBU: res = {24'd0, b};
            MEM_OP_LH:  res = {{16{h[15]}}, h};
            MEM_OP_LHU: res = {16'd0, h};
            default:    res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// Handshake: the master raises req with we/addr/be/wr_data stable and keeps
// them stable until the slave returns ack; the transfer completes in the
// cycle ack is high (rd_data valid in that cycle for reads). There is no
// separate ready: ack is both acceptance and completion.
interface mem_stage_if #(
    parameter int DMEM_AW = 32
);
    logic               req;
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [3:0]         be;
    logic [31:0]        wr_data;
    logic [31:0]        rd_data;
    logic               ack;

    modport master (
        output req, we, addr, be, wr_data,
        input  rd_data, ack
    );

    modport slave (
        input  req, we, addr, be, wr_data,
        output rd_data, ack
    );
endinterface

// File: rtl/mem_stage_reg.sv
// MEM/WB pipeline register. Squash sources (reset, flush, busy) insert a
// bubble; an external stall holds the current contents.
module mem_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    stall,
    input  logic    flush,
    input  logic    busy,
    input  mem_wb_t wb_in,
    output mem_wb_t wb_out
);

    mem_wb_t wb_d;
    mem_wb_t wb_q;

    // Next contents: flush beats stall, stall beats busy, otherwise capture.
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d = MEM_WB_BUBBLE;
        end else if (stall) begin
            wb_d = wb_q;
        end else if (busy) begin
            wb_d = MEM_WB_BUBBLE;
        end else begin
            wb_d = wb_in;
        end
    end

    // Register with synchronous reset to the bubble value.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= MEM_WB_BUBBLE;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_out = wb_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: store lane alignment, load extraction/extension,
// misalignment detection, bus wait-state handling and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_AW = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [EXP_CODE_W-1:0]   ex_exp_code,
    input  logic [31:0]             ex_pc,
    input  logic                    ex_en,
    input  mem_op_e                 ex_mem_op,
    input  logic [31:0]             ex_mem_wr_data,
    input  logic [4:0]              ex_rd_addr,
    input  logic                    ex_gpr_we_,
    input  logic [31:0]             ex_out,
    input  logic [HART_STATE_W-1:0] ex_hart_st,
    mem_stage_if.master             dmem,
    output logic                    mem_busy,
    output logic [31:0]             mem_fwd_data,
    output logic [EXP_CODE_W-1:0]   mem_exp_code,
    output logic [31:0]             mem_pc,
    output logic                    mem_en,
    output logic [4:0]              mem_rd_addr,
    output logic                    mem_gpr_we_,
    output logic [31:0]             mem_out,
    output logic [HART_STATE_W-1:0] mem_hart_st,
    output mem_state_e              state_dbg
);

    logic is_load, is_store, is_half, is_word;
    logic no_exp, misalign, access_valid;
    logic [3:0]         req_be;
    logic [31:0]        req_wdata;
    logic [DMEM_AW-1:0] req_addr;

    mem_state_e         state_d, state_q;
    logic [31:0]        rbuf_d, rbuf_q;
    logic               lat_we_d, lat_we_q;
    logic [DMEM_AW-1:0] lat_addr_d, lat_addr_q;
    logic [3:0]         lat_be_d, lat_be_q;
    logic [31:0]        lat_wdata_d, lat_wdata_q;

    logic [31:0] load_data;
    mem_wb_t     wb_in, wb_out;

    // Decode the op and qualify the access against exceptions/alignment.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (ex_mem_op)
            MEM_OP_LB, MEM_OP_LBU: is_load = 1'b1;
            MEM_OP_LH, MEM_OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            MEM_OP_LW:             begin is_load = 1'b1; is_word = 1'b1; end
            MEM_OP_SB:             is_store = 1'b1;
            MEM_OP_SH:             begin is_store = 1'b1; is_half = 1'b1; end
            MEM_OP_SW:             begin is_store = 1'b1; is_word = 1'b1; end
            default:               ;
        endcase
        no_exp       = (ex_exp_code == EXP_NONE);
        misalign     = ex_en & no_exp &
                       ((is_half & ex_out[0]) | (is_word & (ex_out[1:0] != 2'b00)));
        access_valid = ex_en & no_exp & (ex_mem_op != MEM_OP_NOP) & ~misalign;
    end

    // Byte lanes and replicated store data; loads always read the full word.
    always_comb begin
        req_addr = {ex_out[DMEM_AW-1:2], 2'b00};
        case (ex_mem_op)
            MEM_OP_SB: begin
                req_be    = 4'b0001 << ex_out[1:0];
                req_wdata = {4{ex_mem_wr_data[7:0]}};
            end
            MEM_OP_SH: begin
                req_be    = ex_out[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{ex_mem_wr_data[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = ex_mem_wr_data;
            end
        endcase
    end

    // Bus FSM: issue from IDLE, stretch in WAIT, park read data in HOLD while
    // stalled, and in DRAIN finish a flushed transfer from the latched request
    // (upstream may already present a different instruction).
    always_comb begin
        state_d      = state_q;
        rbuf_d       = rbuf_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_be_d     = lat_be_q;
        lat_wdata_d  = lat_wdata_q;
        dmem.req     = 1'b0;
        dmem.we      = is_store;
        dmem.addr    = req_addr;
        dmem.be      = req_be;
        dmem.wr_data = req_wdata;
        mem_busy     = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                dmem.req = access_valid;
                if (access_valid) begin
                    lat_we_d    = is_store;
                    lat_addr_d  = req_addr;
                    lat_be_d    = req_be;
                    lat_wdata_d = req_wdata;
                    if (dmem.ack) begin
                        if (stall && !flush) begin
                            rbuf_d  = dmem.rd_data;
                            state_d = MEM_HOLD;
                        end
                    end else begin
                        mem_busy = 1'b1;
                        state_d  = flush ? MEM_DRAIN : MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                dmem.req     = 1'b1;
                dmem.we      = lat_we_q;
                dmem.addr    = lat_addr_q;
                dmem.be      = lat_be_q;
                dmem.wr_data = lat_wdata_q;
                if (dmem.ack) begin
                    if (stall && !flush) begin
                        rbuf_d  = dmem.rd_data;
                        state_d = MEM_HOLD;
                    end else begin
                        state_d = MEM_IDLE;
                    end
                end else begin
                    mem_busy = 1'b1;
                    if (flush) state_d = MEM_DRAIN;
                end
            end
            MEM_HOLD: begin
                if (!stall || flush) state_d = MEM_IDLE;
            end
            MEM_DRAIN: begin
                // Busy through the ack cycle too: that ack belongs to the
                // squashed access, so the instruction now in MEM must not
                // complete on it.
                dmem.req     = 1'b1;
                dmem.we      = lat_we_q;
                dmem.addr    = lat_addr_q;
                dmem.be      = lat_be_q;
                dmem.wr_data = lat_wdata_q;
                mem_busy     = 1'b1;
                if (dmem.ack) state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // FSM state, read buffer and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MEM_IDLE;
            rbuf_q      <= 32'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_be_q    <= 4'd0;
            lat_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rbuf_q      <= rbuf_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_be_q    <= lat_be_d;
            lat_wdata_q <= lat_wdata_d;
        end
    end

    // Stage result (also forwarded to EX) and the MEM/WB capture value.
    always_comb begin
        load_data = (state_q == MEM_HOLD) ? rbuf_q : dmem.rd_data;
        if (access_valid && is_load) begin
            mem_fwd_data = load_extend(ex_mem_op, ex_out[1:0], load_data);
        end else begin
            mem_fwd_data = ex_out;
        end
        wb_in.exp_code = misalign ? (is_load ? EXP_LD_MISALIGN : EXP_ST_MISALIGN)
                                  : ex_exp_code;
        wb_in.pc       = ex_pc;
        wb_in.en       = ex_en;
        wb_in.rd_addr  = ex_rd_addr;
        wb_in.gpr_we_  = ex_gpr_we_ | misalign;
        wb_in.out      = mem_fwd_data;
        wb_in.hart_st  = ex_hart_st;
    end

    mem_reg u_mem_reg (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .flush  (flush),
        .busy   (mem_busy),
        .wb_in  (wb_in),
        .wb_out (wb_out)
    );

    assign mem_exp_code = wb_out.exp_code;
    assign mem_pc       = wb_out.pc;
    assign mem_en       = wb_out.en;
    assign mem_rd_addr  = wb_out.rd_addr;
    assign mem_gpr_we_  = wb_out.gpr_we_;
    assign mem_out      = wb_out.out;
    assign mem_hart_st  = wb_out.hart_st;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized single accesses,
// checked against an arithmetic model of lanes, extension and timing.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    stall = 1'b0;
    logic                    flush = 1'b0;
    logic [EXP_CODE_W-1:0]   ex_exp_code = '0;
    logic [31:0]             ex_pc = '0;
    logic                    ex_en = 1'b0;
    mem_op_e                 ex_mem_op = MEM_OP_NOP;
    logic [31:0]             ex_mem_wr_data = '0;
    logic [4:0]              ex_rd_addr = '0;
    logic                    ex_gpr_we_ = 1'b1;
    logic [31:0]             ex_out = '0;
    logic [HART_STATE_W-1:0] ex_hart_st = '0;
    logic                    mem_busy;
    logic [31:0]             mem_fwd_data;
    logic [EXP_CODE_W-1:0]   mem_exp_code;
    logic [31:0]             mem_pc;
    logic                    mem_en;
    logic [4:0]              mem_rd_addr;
    logic                    mem_gpr_we_;
    logic [31:0]             mem_out;
    logic [HART_STATE_W-1:0] mem_hart_st;
    mem_state_e              state_dbg;

    mem_stage_if #(.DMEM_AW(32)) dmem_bus();

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_out = '0;
    logic        last_en = 1'b0;

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    mem_stage #(.DMEM_AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_exp_code    (ex_exp_code),
        .ex_pc          (ex_pc),
        .ex_en          (ex_en),
        .ex_mem_op      (ex_mem_op),
        .ex_mem_wr_data (ex_mem_wr_data),
        .ex_rd_addr     (ex_rd_addr),
        .ex_gpr_we_     (ex_gpr_we_),
        .ex_out         (ex_out),
        .ex_hart_st     (ex_hart_st),
        .dmem           (dmem_bus),
        .mem_busy       (mem_busy),
        .mem_fwd_data   (mem_fwd_data),
        .mem_exp_code   (mem_exp_code),
        .mem_pc         (mem_pc),
        .mem_en         (mem_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_gpr_we_    (mem_gpr_we_),
        .mem_out        (mem_out),
        .mem_hart_st    (mem_hart_st),
        .state_dbg      (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: value a load returns, from byte arithmetic on the word.
    function automatic logic [31:0] model_load(input mem_op_e op, input int off,
                                               input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'h0000_00FF;
        h = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (op)
            MEM_OP_LB:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            MEM_OP_LBU: return b;
            MEM_OP_LH:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            MEM_OP_LHU: return h;
            default:    return rdata;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input mem_op_e op, input int off);
        if (op == MEM_OP_SB) return 4'(1 << off);
        if (op == MEM_OP_SH) return (off >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input mem_op_e op, input logic [31:0] wdata);
        if (op == MEM_OP_SB) return (wdata & 32'h0000_00FF) * 32'h0101_0101;
        if (op == MEM_OP_SH) return (wdata & 32'h0000_FFFF) * 32'h0001_0001;
        return wdata;
    endfunction

    // Driver: one instruction through MEM. lat = cycles before ack,
    // hold = cycles stall is high starting at the ack cycle.
    task automatic do_access(input mem_op_e op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [3:0] exp_in, input int lat, input int hold);
        bit          ld, st, half, word, mis, acc;
        int          off;
        logic [31:0] result, held_out;
        logic        held_en, gwe_in, gwe_out;
        logic [3:0]  exp_out;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  hs;
        ld   = op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
        st   = op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
        half = op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
        word = op inside {MEM_OP_LW, MEM_OP_SW};
        off  = int'(addr % 4);
        mis  = (half && (off % 2 == 1)) || (word && off != 0);
        acc  = (exp_in == EXP_NONE) && (op != MEM_OP_NOP) && !mis;
        if (exp_in != EXP_NONE) exp_out = exp_in;
        else if (mis)           exp_out = ld ? EXP_LD_MISALIGN : EXP_ST_MISALIGN;
        else                    exp_out = EXP_NONE;
        gwe_in  = st ? 1'b1 : (ld ? 1'b0 : 1'($urandom_range(0, 1)));
        gwe_out = (mis && exp_in == EXP_NONE) ? 1'b1 : gwe_in;
        result  = (acc && ld) ? model_load(op, off, rdata) : addr;
        pc = $urandom;
        rd = 5'($urandom_range(0, 31));
        hs = 2'($urandom_range(0, 3));
        exp_q.push_back(result);

        ex_en = 1'b1; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wdata;
        ex_exp_code = exp_in; ex_gpr_we_ = gwe_in; ex_pc = pc; ex_rd_addr = rd;
        ex_hart_st = hs;

        if (!acc) begin
            dmem_bus.ack = 1'b0;
            stall = 1'b0;
            @(negedge clk);
            check("noacc_req", 32'(dmem_bus.req), 32'd0);
            check("noacc_busy", 32'(mem_busy), 32'd0);
            check("noacc_fwd", mem_fwd_data, result);
            @(posedge clk); #1;
        end else begin
            held_out = (lat > 0) ? 32'd0 : last_out;
            held_en  = (lat > 0) ? 1'b0 : last_en;
            for (int c = 0; c <= lat; c++) begin
                dmem_bus.ack     = (c == lat);
                dmem_bus.rd_data = (c == lat) ? rdata : $urandom;
                stall            = (c == lat) && (hold > 0);
                @(negedge clk);
                check("req", 32'(dmem_bus.req), 32'd1);
                check("req_we", 32'(dmem_bus.we), 32'(st));
                check("req_addr", dmem_bus.addr, addr & 32'hFFFF_FFFC);
                check("req_be", 32'(dmem_bus.be), 32'(model_be(op, off)));
                if (st) check("req_wdata", dmem_bus.wr_data, model_wdata(op, wdata));
                check("busy", 32'(mem_busy), 32'(c < lat));
                if (c == lat) check("ack_fwd", mem_fwd_data, result);
                @(posedge clk); #1;
                if (c < lat) check("busy_bubble", 32'(mem_en), 32'd0);
            end
            dmem_bus.ack = 1'b0;
            if (hold > 0) begin
                check("hold_out", mem_out, held_out);
                check("hold_en", 32'(mem_en), 32'(held_en));
                for (int h = 0; h < hold; h++) begin
                    stall = (h < hold - 1);
                    dmem_bus.rd_data = $urandom;
                    @(negedge clk);
                    check("hold_req", 32'(dmem_bus.req), 32'd0);
                    check("hold_busy", 32'(mem_busy), 32'd0);
                    check("hold_fwd", mem_fwd_data, result);
                    @(posedge clk); #1;
                    if (stall) check("hold_keep", mem_out, held_out);
                end
                stall = 1'b0;
            end
        end
        // Scoreboard: compare the WB capture with the queued expectation.
        check("cap_out", mem_out, exp_q.pop_front());
        check("cap_en", 32'(mem_en), 32'd1);
        check("cap_exp", 32'(mem_exp_code), 32'(exp_out));
        check("cap_gwe", 32'(mem_gpr_we_), 32'(gwe_out));
        check("cap_pc", mem_pc, pc);
        check("cap_rd", 32'(mem_rd_addr), 32'(rd));
        check("cap_hart", 32'(mem_hart_st), 32'(hs));
        last_out = result;
        last_en  = 1'b1;
    endtask

    initial begin
        dmem_bus.ack     = 1'b0;
        dmem_bus.rd_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", 32'(mem_en), 32'd0);
        check("rst_gwe", 32'(mem_gpr_we_), 32'd1);
        check("rst_out", mem_out, 32'd0);
        check("rst_pc", mem_pc, 32'd0);
        check("rst_exp", 32'(mem_exp_code), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(MEM_IDLE));
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(dmem_bus.req), 32'd0);
        @(posedge clk); #1;

        // Directed scenarios
        do_access(MEM_OP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, EXP_NONE, 0, 0);
        do_access(MEM_OP_LB, 32'h103, 32'h0, 32'h8011_2233, EXP_NONE, 3, 0);
        check("tp_lb", mem_out, 32'hFFFF_FF80);
        do_access(MEM_OP_LBU, 32'h103, 32'h0, 32'h8011_2233, EXP_NONE, 0, 0);
        check("tp_lbu", mem_out, 32'h0000_0080);
        do_access(MEM_OP_SH, 32'h102, 32'h0000_ABCD, 32'h0, EXP_NONE, 1, 0);
        do_access(MEM_OP_LH, 32'h101, 32'h0, 32'h0, EXP_NONE, 0, 0);
        check("tp_lh_mis", 32'(mem_exp_code), 32'(EXP_LD_MISALIGN));
        do_access(MEM_OP_LW, 32'h200, 32'h0, 32'h1234_5678, EXP_NONE, 0, 2);
        check("tp_lw_hold", mem_out, 32'h1234_5678);

        // Flush while a store waits: the transfer must still run to ack.
        ex_en = 1'b1; ex_mem_op = MEM_OP_SW; ex_out = 32'h40;
        ex_mem_wr_data = 32'h1122_3344; ex_exp_code = EXP_NONE; ex_gpr_we_ = 1'b1;
        dmem_bus.ack = 1'b0;
        @(negedge clk);
        check("fl_issue_req", 32'(dmem_bus.req), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_wait_busy", 32'(mem_busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; ex_en = 1'b0; ex_out = $urandom; ex_mem_wr_data = $urandom;
        check("fl_bubble", 32'(mem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            dmem_bus.ack = (i == 2);
            @(negedge clk);
            check("drain_req", 32'(dmem_bus.req), 32'd1);
            check("drain_addr", dmem_bus.addr, 32'h40);
            check("drain_wdata", dmem_bus.wr_data, 32'h1122_3344);
            check("drain_busy", 32'(mem_busy), 32'd1);
            @(posedge clk); #1;
            check("drain_bubble", 32'(mem_en), 32'd0);
        end
        dmem_bus.ack = 1'b0;
        check("drain_idle", 32'(state_dbg), 32'(MEM_IDLE));
        @(negedge clk);
        check("drain_done_req", 32'(dmem_bus.req), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting on a load.
        ex_en = 1'b1; ex_mem_op = MEM_OP_LW; ex_out = 32'h300; ex_gpr_we_ = 1'b0;
        @(posedge clk); #1;
        check("rw_wait", 32'(state_dbg), 32'(MEM_WAIT));
        reset = 1'b1; ex_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rw_state", 32'(state_dbg), 32'(MEM_IDLE));
        check("rw_en", 32'(mem_en), 32'd0);
        check("rw_gwe", 32'(mem_gpr_we_), 32'd1);
        @(negedge clk);
        check("rw_req", 32'(dmem_bus.req), 32'd0);
        @(posedge clk); #1;
        last_out = '0;
        last_en  = 1'b0;

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            mem_op_e     op;
            logic [3:0]  e;
            int          lat, hold;
            op   = mem_op_e'($urandom_range(0, 8));
            e    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : EXP_NONE;
            lat  = $urandom_range(0, 3);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            do_access(op, $urandom, $urandom, $urandom, e, lat, hold);
        end
        ex_en = 1'b0;
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
